// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier result path.
// Holds the product and word widths and the one-hot state encoding
// used by product_collector.
package mul_pkg;

  localparam int PROD_W = 67;
  localparam int WORD_W = 32;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_LO   = 3'b010;
  localparam logic [2:0] ST_HI   = 3'b100;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LO   = ST_LO,
    HI   = ST_HI
  } state_t;

endpackage

// File: rtl/product_collector_if.sv
// Result word stream from product_collector to its consumer.
// Ports:
//   out_data  - 32-bit result word
//   out_valid - out_data is valid
//   out_ready - consumer accepts the word
//   out_last  - current word is the high word of the product
interface product_collector_if;
  import mul_pkg::*;

  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/product_collector_sign_fit_check.sv
// Reports whether the bits of value from TOP up to the MSB are all equal,
// i.e. whether value fits in a signed field TOP+1 bits wide.
// Ports:
//   value     - input word, WIDTH bits
//   all_equal - 1 when value[WIDTH-1:TOP] is all zeros or all ones
module sign_fit_check #(
  parameter int WIDTH = 67,
  parameter int TOP   = 63
) (
  input  logic [WIDTH-1:0] value,
  output logic             all_equal
);

  // Arithmetic shift leaves a sign extension of value[WIDTH-1:TOP], which is
  // all zeros or all ones exactly when those upper bits agree.
  logic [WIDTH-1:0] shifted;

  assign shifted   = WIDTH'($signed(value) >>> TOP);
  assign all_equal = (shifted == '0) || (&shifted);

endmodule

// File: rtl/product_collector.sv
// Collects 67-bit signed products from the multiplier and emits each as two
// 32-bit words (low then high) on a valid/ready stream. One extra product
// can wait in a pending register; further products arriving while busy are
// dropped.
// Ports:
//   clk, rst_b  - clock, asynchronous active-low reset
//   done        - one-cycle pulse, product is final
//   product     - signed product from the multiplier
//   stream      - result word stream (master side)
//   ovf         - held product does not fit in 64 bits signed
//   fits32      - held product fits in 32 bits signed
//   busy        - a product is being emitted
//   drop        - a product was discarded this cycle
//   result_cnt  - completed two-word transfers, wrapping
module product_collector
  import mul_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              done,
  input  logic [PROD_W-1:0] product,
  product_collector_if.master stream,
  output logic              ovf,
  output logic              fits32,
  output logic              busy,
  output logic              drop,
  output logic [CNT_W-1:0]  result_cnt
);

  state_t            state, state_nxt;
  logic [PROD_W-1:0] hold;
  logic [PROD_W-1:0] pend;
  logic              pend_valid;
  logic              hi_xfer;
  logic              top64_eq;
  logic              top32_eq;

  // The high word is accepted: the current product is finished this cycle.
  assign hi_xfer = (state == HI) && stream.out_ready;
  assign busy    = (state != IDLE);

  // Next state and stream outputs. A finishing product may be followed
  // directly by the pending one or by a product arriving this same cycle,
  // so back-to-back results need no IDLE cycle.
  always_comb begin
    state_nxt        = state;
    stream.out_valid = 1'b0;
    stream.out_last  = 1'b0;
    stream.out_data  = '0;
    drop             = 1'b0;
    case (state)
      IDLE: begin
        if (done) state_nxt = LO;
      end
      LO: begin
        stream.out_valid = 1'b1;
        stream.out_data  = hold[WORD_W-1:0];
        if (stream.out_ready) state_nxt = HI;
      end
      HI: begin
        stream.out_valid = 1'b1;
        stream.out_last  = 1'b1;
        stream.out_data  = hold[2*WORD_W-1:WORD_W];
        if (stream.out_ready) state_nxt = (pend_valid || done) ? LO : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A full pending slot only frees up when the high word goes out now.
    if (done && busy && pend_valid && !hi_xfer) drop = 1'b1;
  end

  // State, hold/pending registers and the completion counter. When the high
  // word leaves with a product pending, the pending one moves to hold and
  // any product arriving at the same time refills the pending slot.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      hold       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      result_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (done) hold <= product;
      end else if (hi_xfer) begin
        result_cnt <= result_cnt + CNT_W'(1);
        if (pend_valid) begin
          hold <= pend;
          if (done) pend <= product;
          else      pend_valid <= 1'b0;
        end else if (done) begin
          hold <= product;
        end
      end else if (done && !pend_valid) begin
        pend       <= product;
        pend_valid <= 1'b1;
      end
    end
  end

  sign_fit_check #(.WIDTH(PROD_W), .TOP(2*WORD_W-1)) u_fit64 (
    .value     (hold),
    .all_equal (top64_eq)
  );

  sign_fit_check #(.WIDTH(PROD_W), .TOP(WORD_W-1)) u_fit32 (
    .value     (hold),
    .all_equal (top32_eq)
  );

  // Range flags describe the held product and are forced low when idle.
  assign ovf    = busy && !top64_eq;
  assign fits32 = busy && top32_eq;

endmodule

// File: tb/tb_product_collector.sv
// Self-checking bench for product_collector: a directed vector table,
// hand-written multi-cycle sequences, and a randomized run compared
// against a queue-based model of the result stream.
module tb_product_collector;
  import mul_pkg::*;

  logic              clk;
  logic              rst_b;
  logic              done;
  logic [PROD_W-1:0] product;
  logic              ovf, fits32, busy, drop;
  logic [7:0]        result_cnt;
  int                checks;
  int                failures;

  product_collector_if stream_if ();

  product_collector #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .done       (done),
    .product    (product),
    .stream     (stream_if),
    .ovf        (ovf),
    .fits32     (fits32),
    .busy       (busy),
    .drop       (drop),
    .result_cnt (result_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic              d;
    logic [PROD_W-1:0] p;
    logic              r;
    logic              v;
    logic [31:0]       dat;
    logic              l;
    logic              b;
    logic              f;
    logic              o;
    logic              dr;
    logic [7:0]        cnt;
  } vec_t;

  localparam logic signed [66:0] MAX32 = 67'sd2147483647;
  localparam logic signed [66:0] MIN32 = -67'sd2147483648;
  localparam logic signed [66:0] MAX64 = 67'sd9223372036854775807;
  localparam logic signed [66:0] MIN64 = -67'sd9223372036854775808;

  function automatic vec_t mk(logic d, logic [PROD_W-1:0] p, logic r, logic v,
                              logic [31:0] dat, logic l, logic b, logic f,
                              logic o, logic dr, logic [7:0] cnt);
    vec_t x;
    x.d = d; x.p = p; x.r = r; x.v = v; x.dat = dat; x.l = l;
    x.b = b; x.f = f; x.o = o; x.dr = dr; x.cnt = cnt;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic d, input logic [PROD_W-1:0] p, input logic r);
    done                = d;
    product             = p;
    stream_if.out_ready = r;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic v, input logic [31:0] dat,
                             input logic l, input logic b, input logic f,
                             input logic o, input logic dr);
    logic [38:0] act, exp;
    act = {stream_if.out_valid, stream_if.out_data, stream_if.out_last, busy, fits32, ovf, drop};
    exp = {v, dat, l, b, f, o, dr};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got valid=%b data=%h last=%b busy=%b fits32=%b ovf=%b drop=%b, expected valid=%b data=%h last=%b busy=%b fits32=%b ovf=%b drop=%b",
               name, act[38], act[37:6], act[5], act[4], act[3], act[2], act[1],
               v, dat, l, b, f, o, dr);
    end
  endtask

  task automatic checkCnt(input string name, input logic [7:0] exp);
    checks++;
    if (result_cnt !== exp) begin
      failures++;
      $display("[TB] FAIL %s: result_cnt got %0d expected %0d", name, result_cnt, exp);
    end
  endtask

  function automatic logic [PROD_W-1:0] rand_product();
    logic [95:0]       r;
    logic signed [66:0] v;
    int                w;
    r = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0: w = 16;  1: w = 32;  2: w = 33;  3: w = 40;
      4: w = 63;  5: w = 64;  6: w = 65;  default: w = 67;
    endcase
    v = r[66:0];
    if (w < 67) begin
      v = v << (67 - w);
      v = v >>> (67 - w);
    end
    return v;
  endfunction

  localparam logic [PROD_W-1:0] NEG6408 = -67'sd6408;
  localparam logic [PROD_W-1:0] NEG5    = -67'sd5;

  vec_t vecs[13];

  initial begin
    logic [PROD_W-1:0] model_q[$];
    logic [PROD_W-1:0] head;
    logic signed [66:0] ph;
    int                widx;
    logic [7:0]        model_cnt;
    logic              rd, rr, ev, el, ef, eo, edr;
    logic [PROD_W-1:0] rp;
    logic [31:0]       edat;

    checks              = 0;
    failures            = 0;
    rst_b               = 1'b0;
    done                = 1'b0;
    product             = '0;
    stream_if.out_ready = 1'b0;

    // Basic, negative and range-flag products, each from IDLE.
    vecs[0]  = mk(1, 67'd6408, 1, 0, 32'h0,        0, 0, 0, 0, 0, 8'd0);
    vecs[1]  = mk(0, '0,       1, 1, 32'h00001908, 0, 1, 1, 0, 0, 8'd0);
    vecs[2]  = mk(0, '0,       1, 1, 32'h00000000, 1, 1, 1, 0, 0, 8'd0);
    vecs[3]  = mk(1, NEG6408,  1, 0, 32'h0,        0, 0, 0, 0, 0, 8'd1);
    vecs[4]  = mk(0, '0,       1, 1, 32'hFFFFE6F8, 0, 1, 1, 0, 0, 8'd1);
    vecs[5]  = mk(0, '0,       1, 1, 32'hFFFFFFFF, 1, 1, 1, 0, 0, 8'd1);
    vecs[6]  = mk(1, 67'h100_0000_0000, 1, 0, 32'h0, 0, 0, 0, 0, 0, 8'd2);
    vecs[7]  = mk(0, '0,       1, 1, 32'h00000000, 0, 1, 0, 0, 0, 8'd2);
    vecs[8]  = mk(0, '0,       1, 1, 32'h00000100, 1, 1, 0, 0, 0, 8'd2);
    vecs[9]  = mk(1, 67'h2_0000_0000_0000_0000, 1, 0, 32'h0, 0, 0, 0, 0, 0, 8'd3);
    vecs[10] = mk(0, '0,       1, 1, 32'h00000000, 0, 1, 0, 1, 0, 8'd3);
    vecs[11] = mk(0, '0,       1, 1, 32'h00000000, 1, 1, 0, 1, 0, 8'd3);
    vecs[12] = mk(0, '0,       1, 0, 32'h0,        0, 0, 0, 0, 0, 8'd4);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 0, 32'h0, 0, 0, 0, 0, 0);
    checkCnt("reset_cnt", 8'd0);
    rst_b = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].d, vecs[i].p, vecs[i].r);
      checkOutput($sformatf("vec%0d", i), vecs[i].v, vecs[i].dat, vecs[i].l,
                  vecs[i].b, vecs[i].f, vecs[i].o, vecs[i].dr);
      checkCnt($sformatf("vec%0d_cnt", i), vecs[i].cnt);
      tick();
    end

    // Backpressure in LO for five cycles.
    applyStimulus(1, 67'h0123_4567_89AB_CDEF, 0);
    checkOutput("bp_idle", 0, 32'h0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, '0, 0);
      checkOutput($sformatf("bp_hold%0d", k), 1, 32'h89ABCDEF, 0, 1, 0, 0, 0);
      tick();
    end
    applyStimulus(0, '0, 1);
    checkOutput("bp_lo", 1, 32'h89ABCDEF, 0, 1, 0, 0, 0);
    checkCnt("bp_cnt_before", 8'd4);
    tick();
    applyStimulus(0, '0, 1);
    checkOutput("bp_hi", 1, 32'h01234567, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(0, '0, 1);
    checkOutput("bp_end", 0, 32'h0, 0, 0, 0, 0, 0);
    checkCnt("bp_cnt_after", 8'd5);

    // Three products while stalled in LO: second pends, third drops.
    applyStimulus(1, 67'd100, 0);
    checkOutput("ov_idle", 0, 32'h0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, NEG5, 0);
    checkOutput("ov_pend", 1, 32'd100, 0, 1, 1, 0, 0);
    tick();
    applyStimulus(1, 67'd7, 0);
    checkOutput("ov_drop", 1, 32'd100, 0, 1, 1, 0, 1);
    tick();
    applyStimulus(0, '0, 0);
    checkOutput("ov_nodrop", 1, 32'd100, 0, 1, 1, 0, 0);
    tick();
    applyStimulus(0, '0, 1);
    checkOutput("ov_w0", 1, 32'd100, 0, 1, 1, 0, 0);
    tick();
    checkOutput("ov_w1", 1, 32'h0, 1, 1, 1, 0, 0);
    tick();
    checkOutput("ov_w2", 1, 32'hFFFFFFFB, 0, 1, 1, 0, 0);
    tick();
    checkOutput("ov_w3", 1, 32'hFFFFFFFF, 1, 1, 1, 0, 0);
    tick();
    checkOutput("ov_end", 0, 32'h0, 0, 0, 0, 0, 0);
    checkCnt("ov_cnt", 8'd7);

    // New product on the same cycle as the high word, nothing pending.
    applyStimulus(1, 67'h3_0000_0011, 1);
    checkOutput("sc_idle", 0, 32'h0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, '0, 1);
    checkOutput("sc_lo_a", 1, 32'h11, 0, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 67'h22, 1);
    checkOutput("sc_hi_a", 1, 32'h3, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(0, '0, 1);
    checkOutput("sc_lo_b", 1, 32'h22, 0, 1, 1, 0, 0);
    tick();
    checkOutput("sc_hi_b", 1, 32'h0, 1, 1, 1, 0, 0);
    tick();
    checkOutput("sc_end", 0, 32'h0, 0, 0, 0, 0, 0);
    checkCnt("sc_cnt", 8'd9);

    // Reset while in HI; the next product right after release is captured.
    applyStimulus(1, 67'hAA_0000_00BB, 1);
    tick();
    applyStimulus(0, '0, 1);
    checkOutput("rs_lo", 1, 32'hBB, 0, 1, 0, 0, 0);
    tick();
    applyStimulus(0, '0, 1);
    checkOutput("rs_hi", 1, 32'hAA, 1, 1, 0, 0, 0);
    rst_b = 1'b0;
    #1;
    checkOutput("rs_async", 0, 32'h0, 0, 0, 0, 0, 0);
    checkCnt("rs_cnt_zero", 8'd0);
    tick();
    rst_b = 1'b1;
    applyStimulus(1, 67'h33, 0);
    checkOutput("rs_release", 0, 32'h0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, '0, 1);
    checkOutput("rs_lo_new", 1, 32'h33, 0, 1, 1, 0, 0);
    tick();
    checkOutput("rs_hi_new", 1, 32'h0, 1, 1, 1, 0, 0);
    tick();
    checkOutput("rs_end", 0, 32'h0, 0, 0, 0, 0, 0);
    checkCnt("rs_cnt", 8'd1);

    // Randomized run against a queue model: up to two products outstanding,
    // the head emits low then high word, a slot frees as its high word goes.
    applyStimulus(0, '0, 0);
    rst_b = 1'b0;
    tick();
    rst_b     = 1'b1;
    widx      = 0;
    model_cnt = '0;
    model_q.delete();
    for (int c = 0; c < 1500; c++) begin
      rd = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 3) != 0);
      rp = rand_product();
      applyStimulus(rd, rp, rr);
      if (model_q.size() == 0) begin
        ev = 0; edat = '0; el = 0; ef = 0; eo = 0;
      end else begin
        head = model_q[0];
        ph   = head;
        ev   = 1;
        el   = (widx == 1);
        edat = el ? head[63:32] : head[31:0];
        ef   = (ph >= MIN32) && (ph <= MAX32);
        eo   = (ph < MIN64) || (ph > MAX64);
      end
      edr = rd && (model_q.size() == 2) && !(widx == 1 && rr);
      checkOutput($sformatf("rand%0d", c), ev, edat, el, ev, ef, eo, edr);
      checkCnt($sformatf("rand%0d_cnt", c), model_cnt);
      if (model_q.size() > 0 && rr) begin
        if (widx == 0) begin
          widx = 1;
        end else begin
          void'(model_q.pop_front());
          widx      = 0;
          model_cnt = model_cnt + 8'd1;
        end
      end
      if (rd && !edr) model_q.push_back(rp);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
